mem_stage: RTL and testbench

Memory stage of the NPC pipeline, directly downstream of the execute stage. It accepts the execute-to-memory bus over a valid/ready handshake and aligns and sign/zero-extends load data. It produces the register write-back payload for the write-back stage. A two-entry buffer (main + skid) keeps `mem_to_exe_ready` a pure register output, so the execute stage's ready path never depends combinationally on the write-back stage.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: load alignment / extension and a main+skid
// output buffer so upstream ready is a pure register output.
module mem_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2*DATA_WIDTH+ADDR_WIDTH+3:0] exe_to_mem_bus,
  input  logic                               exe_to_mem_valid,
  output logic                               mem_to_exe_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]     mem_to_wb_bus,
  output logic                               mem_to_wb_valid,
  input  logic                               wb_to_mem_ready,
  output logic                               mem_fwd_valid,
  output logic [ADDR_WIDTH-1:0]              mem_fwd_addr,
  output logic [DATA_WIDTH-1:0]              mem_fwd_data,
  output logic                               mem_misalign
);

  localparam int OW = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic                  in_reg_w;
  logic [ADDR_WIDTH-1:0] in_reg_addr;
  logic [DATA_WIDTH-1:0] in_alu;
  logic [2:0]            in_ld_inst;
  logic [DATA_WIDTH-1:0] in_ld_data;

  assign {in_reg_w, in_reg_addr, in_alu,
          in_ld_inst, in_ld_data} = exe_to_mem_bus;

  logic [1:0]            off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  is_none;
  logic                  is_lb;
  logic                  is_lh;
  logic                  is_lbu;
  logic                  is_lhu;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_mis;

  assign off     = in_alu[1:0];
  assign ld_byte = in_ld_data[{off, 3'b000} +: 8];
  assign ld_half = in_ld_data[{off[1], 4'b0000} +: 16];
  assign is_none = (in_ld_inst == 3'b000);
  assign is_lb   = (in_ld_inst == 3'b001);
  assign is_lh   = (in_ld_inst == 3'b010);
  assign is_lbu  = (in_ld_inst == 3'b100);
  assign is_lhu  = (in_ld_inst == 3'b101);

  // Decode load kind into aligned, extended write-back data.
  always_comb begin
    dec_data = in_ld_data;
    dec_mis  = 1'b0;
    unique case (1'b1)
      is_none: dec_data = in_alu;
      is_lb: begin
        dec_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      end
      is_lbu: begin
        dec_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      end
      is_lh: begin
        dec_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        dec_mis  = off[0];
      end
      is_lhu: begin
        dec_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
        dec_mis  = off[0];
      end
      default: begin
        dec_data = in_ld_data;
        dec_mis  = |off;
      end
    endcase
  end

  logic [OW:0] new_ent;
  logic [OW:0] main_q;
  logic [OW:0] skid_q;
  logic [1:0]  state;
  logic        in_fire;
  logic        out_fire;

  assign new_ent  = {dec_mis, in_reg_w, in_reg_addr, dec_data};
  assign in_fire  = exe_to_mem_valid & mem_to_exe_ready;
  assign out_fire = mem_to_wb_valid & wb_to_mem_ready;

  // Two-entry FIFO: main feeds write-back, skid absorbs one stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= new_ent;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= new_ent;
          end else if (in_fire) begin
            skid_q <= new_ent;
            state  <= FULL;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign mem_to_exe_ready = ~state[1];
  assign mem_to_wb_valid  = state[0];
  assign mem_to_wb_bus    = main_q[OW-1:0];
  assign mem_fwd_valid    = state[0] & main_q[OW-1];
  assign mem_fwd_addr     = main_q[OW-2:DATA_WIDTH];
  assign mem_fwd_data     = main_q[DATA_WIDTH-1:0];
  assign mem_misalign     = state[0] & main_q[OW];

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal checks plus randomized
// traffic against a queue-based reference of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [72:0] exe_to_mem_bus = '0;
  logic        exe_to_mem_valid = 1'b0;
  logic        mem_to_exe_ready;
  logic [37:0] mem_to_wb_bus;
  logic        mem_to_wb_valid;
  logic        wb_to_mem_ready = 1'b1;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        mem_misalign;

  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  logic [38:0] q[$];

  mem_stage dut (
    .clk(clk),
    .rst(rst),
    .exe_to_mem_bus(exe_to_mem_bus),
    .exe_to_mem_valid(exe_to_mem_valid),
    .mem_to_exe_ready(mem_to_exe_ready),
    .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_wb_valid(mem_to_wb_valid),
    .wb_to_mem_ready(wb_to_mem_ready),
    .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data),
    .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [72:0] mk(input logic w,
                                     input logic [4:0] a,
                                     input logic [31:0] alu,
                                     input logic [2:0] li,
                                     input logic [31:0] ld);
    return {w, a, alu, li, ld};
  endfunction

  // Reference: {misalign, regW, addr, data} from the load rules.
  function automatic logic [38:0] model(input logic [72:0] b);
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] bv;
    logic [31:0] hv;
    logic [31:0] d;
    int unsigned li;
    int unsigned off;
    logic mis;
    alu = b[66:35];
    ld  = b[31:0];
    li  = int'(b[34:32]);
    off = alu % 4;
    bv  = (ld >> (8 * off)) % 256;
    hv  = (ld >> (16 * (off / 2))) % 65536;
    mis = 1'b0;
    case (li)
      0: d = alu;
      1: d = (bv >= 128) ? bv - 32'd256 : bv;
      2: d = (hv >= 32768) ? hv - 32'd65536 : hv;
      4: d = bv;
      5: d = hv;
      default: d = ld;
    endcase
    if (li == 2 || li == 5) mis = (off % 2) != 0;
    else if (li == 3 || li >= 6) mis = off != 0;
    return {mis, b[72], b[71:67], d};
  endfunction

  // Cycle-by-cycle comparison against the reference queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("ready", 64'(mem_to_exe_ready), 64'(q.size() < 2));
      chk("wb_valid", 64'(mem_to_wb_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("wb_bus", 64'(mem_to_wb_bus), 64'(q[0][37:0]));
        chk("fwd_valid", 64'(mem_fwd_valid), 64'(q[0][37]));
        chk("fwd_addr", 64'(mem_fwd_addr), 64'(q[0][36:32]));
        chk("fwd_data", 64'(mem_fwd_data), 64'(q[0][31:0]));
        chk("misalign", 64'(mem_misalign), 64'(q[0][38]));
      end else begin
        chk("fwd_valid_idle", 64'(mem_fwd_valid), 64'd0);
        chk("misalign_idle", 64'(mem_misalign), 64'd0);
      end
      if (mem_to_wb_valid && wb_to_mem_ready && q.size() > 0)
        void'(q.pop_front());
      if (exe_to_mem_valid && mem_to_exe_ready) begin
        q.push_back(model(exe_to_mem_bus));
        n_in++;
      end
    end
  end

  task automatic send(input string nm, input logic [72:0] b,
                      input logic [31:0] ed, input logic em);
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = b;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_model"}, 64'(model(b)[31:0]), 64'(ed));
    chk({nm, "_data"}, 64'(mem_fwd_data), 64'(ed));
    chk({nm, "_mis"}, 64'(mem_misalign), 64'(em));
    chk({nm, "_valid"}, 64'(mem_to_wb_valid), 64'd1);
  endtask

  localparam logic [31:0] LD = 32'h8081_F27F;

  initial begin
    int cyc;
    // Reset held with upstream valid high.
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk(1'b1, 5'd7, 32'h1234, 3'd0, 32'h0);
    @(negedge clk);
    chk("rst_ready", 64'(mem_to_exe_ready), 64'd1);
    chk("rst_wbv", 64'(mem_to_wb_valid), 64'd0);
    chk("rst_bus", 64'(mem_to_wb_bus), 64'd0);
    chk("rst_fwdv", 64'(mem_fwd_valid), 64'd0);
    chk("rst_mis", 64'(mem_misalign), 64'd0);
    @(negedge clk);
    chk("rst_ready2", 64'(mem_to_exe_ready), 64'd1);
    chk("rst_wbv2", 64'(mem_to_wb_valid), 64'd0);
    chk("rst_fdata", 64'(mem_fwd_data), 64'd0);
    chk("rst_faddr", 64'(mem_fwd_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("first_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("first_data", 64'(mem_fwd_data), 64'h1234);

    // Directed load alignment and extension.
    send("lb",  mk(1, 3, 32'h1000_0003, 3'd1, LD), 32'hFFFF_FF80, 0);
    send("lbu", mk(1, 3, 32'h1000_0003, 3'd4, LD), 32'h0000_0080, 0);
    send("lh",  mk(1, 3, 32'h1000_0002, 3'd2, LD), 32'hFFFF_8081, 0);
    send("lhu", mk(1, 3, 32'h1000_0002, 3'd5, LD), 32'h0000_8081, 0);
    send("lw",  mk(1, 3, 32'h1000_0000, 3'd3, LD), 32'h8081_F27F, 0);
    send("nold", mk(1, 5, 32'hDEAD_BEEF, 3'd0, LD), 32'hDEAD_BEEF, 0);
    chk("nold_bus", 64'(mem_to_wb_bus), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
    chk("nold_fwdv", 64'(mem_fwd_valid), 64'd1);
    chk("nold_faddr", 64'(mem_fwd_addr), 64'd5);
    send("lh_mis", mk(1, 3, 32'h1000_0001, 3'd2, LD), 32'hFFFF_F27F, 1);
    send("lw_mis", mk(1, 3, 32'h1000_0002, 3'd3, LD), 32'h8081_F27F, 1);

    // Backpressure: A and B land, C waits upstream.
    @(posedge clk); #1;
    wb_to_mem_ready  = 1'b0;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk(1, 1, 32'hA, 3'd0, 0);
    @(posedge clk); #1;
    exe_to_mem_bus   = mk(1, 2, 32'hB, 3'd0, 0);
    @(posedge clk); #1;
    exe_to_mem_bus   = mk(1, 3, 32'hC, 3'd0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(mem_to_exe_ready), 64'd0);
      chk("bp_holdA", 64'(mem_fwd_data), 64'hA);
      @(posedge clk); #1;
    end
    wb_to_mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_holdA_last", 64'(mem_fwd_data), 64'hA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_back", 64'(mem_to_exe_ready), 64'd1);
    chk("bp_B", 64'(mem_fwd_data), 64'hB);
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("bp_C", 64'(mem_fwd_data), 64'hC);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", 64'(mem_to_wb_valid), 64'd0);

    // Random traffic with one mid-run reset.
    n_in = 0;
    cyc  = 0;
    while (n_in < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      rst = (cyc == 5000);
      exe_to_mem_valid = ($urandom_range(3) != 0);
      wb_to_mem_ready  = ($urandom_range(3) != 0);
      exe_to_mem_bus   = mk(1'($urandom), 5'($urandom), $urandom,
                            3'($urandom), $urandom);
      cyc++;
    end
    chk("rand_count", 64'(n_in >= 10000), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exe_to_mem_valid = 1'b0;
    wb_to_mem_ready  = 1'b1;
    for (int i = 0; i < 8; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_wbv", 64'(mem_to_wb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
